// File: rtl/stream_arbiter_4.sv
// -----------------------------------------------------------------------------
// stream_arbiter_4
//
// Four-way message-level arbiter. Four producers share one 32-bit stb/ack
// output stream. One requester is granted at a time, picked round-robin after
// the previously released requester. The grant is held for a whole message.
// A message ends when a word equal to TERMINATOR is forwarded or when
// MAX_WORDS words have been forwarded. A granted producer that leaves its stb
// low for TIMEOUT consecutive accept cycles loses the grant, and the sticky
// exception flag is raised.
//
// Each word takes two cycles: one cycle with the producer's ack high (ACCEPT)
// and at least one cycle presenting the captured word downstream (SEND).
//
// Ports
//   clk                  single clock, rising edge
//   rst                  synchronous reset, active high
//   input_0..input_3     requester data (32 bit)
//   input_k_stb          requester data valid
//   input_k_ack          word accepted from requester k
//   output_out           arbitrated data (32 bit)
//   output_out_stb       output data valid
//   output_out_ack       downstream accepts the output word
//   exception            sticky stall-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module stream_arbiter_4 #(
  parameter logic [31:0] TERMINATOR = 32'h0000_000A,
  parameter int unsigned MAX_WORDS  = 256,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_0,
  input  logic        input_0_stb,
  output logic        input_0_ack,
  input  logic [31:0] input_1,
  input  logic        input_1_stb,
  output logic        input_1_ack,
  input  logic [31:0] input_2,
  input  logic        input_2_stb,
  output logic        input_2_ack,
  input  logic [31:0] input_3,
  input  logic        input_3_stb,
  output logic        input_3_ack,
  output logic [31:0] output_out,
  output logic        output_out_stb,
  input  logic        output_out_ack,
  output logic        exception
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

  localparam logic [31:0] MAX_WORDS_C = 32'(MAX_WORDS);
  localparam logic [31:0] TIMEOUT_C   = 32'(TIMEOUT);

  // Round-robin pick: the first requester after `last` in cyclic order.
  // Only meaningful when req is non-zero.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [3:0] req);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic        exc_q, exc_d;
  logic [3:0]  ack_q, ack_d;
  logic        out_stb_q, out_stb_d;

  logic [31:0] in_data_s [4];
  logic [3:0]  in_stb_s;
  logic [31:0] idle_cnt_inc_s;
  logic        release_s;

  assign in_data_s[0] = input_0;
  assign in_data_s[1] = input_1;
  assign in_data_s[2] = input_2;
  assign in_data_s[3] = input_3;
  assign in_stb_s     = {input_3_stb, input_2_stb, input_1_stb, input_0_stb};

  assign idle_cnt_inc_s = idle_cnt_q + 32'd1;

  // A message ends on the terminator word or when the word limit is reached.
  assign release_s = (hold_q == TERMINATOR) ||
                     ((MAX_WORDS_C != 32'd0) && (word_cnt_q == MAX_WORDS_C));

  // Next-state logic of the IDLE / ACCEPT / SEND controller.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    hold_d     = hold_q;
    word_cnt_d = word_cnt_q;
    idle_cnt_d = idle_cnt_q;
    exc_d      = exc_q;
    case (state_q)
      ST_IDLE: begin
        if (|in_stb_s) begin
          grant_d    = rr_pick(last_q, in_stb_s);
          word_cnt_d = 32'd0;
          idle_cnt_d = 32'd0;
          state_d    = ST_ACCEPT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCEPT: begin
        if (in_stb_s[grant_q]) begin
          hold_d     = in_data_s[grant_q];
          word_cnt_d = word_cnt_q + 32'd1;
          idle_cnt_d = 32'd0;
          state_d    = ST_SEND;
        end else begin
          idle_cnt_d = idle_cnt_inc_s;
          // A stalled producer gives up the grant; the flag stays set.
          if ((TIMEOUT_C != 32'd0) && (idle_cnt_inc_s == TIMEOUT_C)) begin
            exc_d   = 1'b1;
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_SEND: begin
        // Downstream backpressure is waited out indefinitely.
        if (output_out_ack) begin
          if (release_s) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so acks and stb come straight off flops.
  always_comb begin
    ack_d = 4'b0000;
    if (state_d == ST_ACCEPT) begin
      ack_d[grant_d] = 1'b1;
    end else begin
      ack_d = 4'b0000;
    end
    out_stb_d = (state_d == ST_SEND);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'd0;
      last_q     <= 2'd3;
      hold_q     <= 32'd0;
      word_cnt_q <= 32'd0;
      idle_cnt_q <= 32'd0;
      exc_q      <= 1'b0;
      ack_q      <= 4'b0000;
      out_stb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      word_cnt_q <= word_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      exc_q      <= exc_d;
      ack_q      <= ack_d;
      out_stb_q  <= out_stb_d;
    end
  end

  // The ack flops still hold their pre-reset value during the reset cycle;
  // masking with rst keeps a producer from handing over a word that the
  // reset is about to discard.
  assign input_0_ack    = ack_q[0] & ~rst;
  assign input_1_ack    = ack_q[1] & ~rst;
  assign input_2_ack    = ack_q[2] & ~rst;
  assign input_3_ack    = ack_q[3] & ~rst;
  assign output_out     = hold_q;
  assign output_out_stb = out_stb_q;
  assign exception      = exc_q;

endmodule

// File: tb/tb_stream_arbiter_4.sv
module tb_stream_arbiter_4;

  localparam logic [31:0] TERM = 32'h0000_000A;
  localparam int          MAXW = 4;
  localparam int          TOUT = 16;

  logic        clk;
  logic        rst;
  logic [31:0] din [4];
  logic [3:0]  stb;
  logic        out_ack;
  wire         ack0, ack1, ack2, ack3;
  wire  [31:0] output_out;
  wire         output_out_stb;
  wire         exception;

  stream_arbiter_4 #(.TERMINATOR(TERM), .MAX_WORDS(MAXW), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .input_0(din[0]), .input_0_stb(stb[0]), .input_0_ack(ack0),
    .input_1(din[1]), .input_1_stb(stb[1]), .input_1_ack(ack1),
    .input_2(din[2]), .input_2_stb(stb[2]), .input_2_ack(ack2),
    .input_3(din[3]), .input_3_stb(stb[3]), .input_3_ack(ack3),
    .output_out(output_out), .output_out_stb(output_out_stb),
    .output_out_ack(out_ack), .exception(exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          first_out = -1;
  int          stb_cyc = 0;
  int          stall_cnt = 0;
  bit          ack_rand = 1'b0;
  bit          gap_en = 1'b0;
  bit          ack2_early = 1'b0;
  bit          ok;
  logic [31:0] pq [4][$];
  int          seg_pos [4];
  int          gap_left [4];
  logic [31:0] out_log [$];
  int          gnt_log [$];
  logic [31:0] exp_q [$];

  function automatic logic [3:0] acks();
    return {ack3, ack2, ack1, ack0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 4; k++) begin
      if (pq[k].size() == 0) begin
        stb[k] = 1'b0;
      end else if (gap_left[k] > 0) begin
        stb[k] = 1'b0;
        din[k] = pq[k][0];
        gap_left[k]--;
      end else begin
        stb[k] = 1'b1;
        din[k] = pq[k][0];
      end
    end
  endtask

  // One clock: observe handshakes at negedge, update producers after posedge.
  task automatic cycle();
    logic [3:0]  xin;
    logic [31:0] w;
    @(negedge clk);
    xin = stb & acks();
    for (int k = 0; k < 4; k++) if (xin[k]) gnt_log.push_back(k);
    if (ack2 && pq[0].size() > 0) ack2_early = 1'b1;
    if (output_out_stb && out_ack) out_log.push_back(output_out);
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (xin[k]) begin
        w = pq[k].pop_front();
        seg_pos[k]++;
        if (w == TERM || seg_pos[k] == MAXW) seg_pos[k] = 0;
        if (gap_en && seg_pos[k] > 0) gap_left[k] = $urandom_range(0, 3);
      end
    end
    if (ack_rand) out_ack = 1'($urandom_range(0, 1));
    drive_inputs();
  endtask

  task automatic run_until_idle(input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (output_out_stb && first_out < 0) first_out = cyc;
      if (pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
          pq[3].size() == 0 && acks() == 4'b0000 && !output_out_stb) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pq[k].delete();
      seg_pos[k] = 0;
      gap_left[k] = 0;
    end
    drive_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    out_log.delete();
    gnt_log.delete();
    first_out = -1;
    ack2_early = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    out_ack = 1'b1;
    stb = 4'b0000;
    for (int k = 0; k < 4; k++) din[k] = 32'd0;

    // Reset values
    do_reset();
    check("rst_stb", {31'd0, output_out_stb}, 32'd0);
    check("rst_out", output_out, 32'd0);
    check("rst_acks", {28'd0, acks()}, 32'd0);
    check("rst_exc", {31'd0, exception}, 32'd0);

    // Requester 1 sends "Hi\n" with output ack tied high
    pq[1] = '{32'h48, 32'h69, 32'h0A};
    drive_inputs();
    stb_cyc = cyc;
    run_until_idle(100, ok);
    check("hi_done", {31'd0, ok}, 32'd1);
    check("hi_latency", 32'(first_out - stb_cyc), 32'd2);
    check("hi_count", 32'(out_log.size()), 32'd3);
    check("hi_w0", out_log[0], 32'h48);
    check("hi_w1", out_log[1], 32'h69);
    check("hi_w2", out_log[2], 32'h0A);
    cycle();
    check("hi_idle", {27'd0, acks(), output_out_stb}, 32'd0);

    // Requesters 0 and 2 start together: whole message of 0 first
    do_reset();
    pq[0] = '{32'h100, 32'h101, 32'h0A};
    pq[2] = '{32'h200, 32'h201, 32'h0A};
    drive_inputs();
    run_until_idle(100, ok);
    check("pair_done", {31'd0, ok}, 32'd1);
    check("pair_ack2_early", {31'd0, ack2_early}, 32'd0);
    exp_q = '{32'h100, 32'h101, 32'h0A, 32'h200, 32'h201, 32'h0A};
    check("pair_count", 32'(out_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("pair_w%0d", i), (i < out_log.size()) ? out_log[i] : 32'hDEADBEEF, exp_q[i]);

    // All four stream 1-word messages: round-robin order
    do_reset();
    for (int k = 0; k < 4; k++) pq[k] = '{TERM, TERM};
    drive_inputs();
    run_until_idle(200, ok);
    check("rr_done", {31'd0, ok}, 32'd1);
    check("rr_count", 32'(gnt_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_g%0d", i), (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hDEADBEEF, 32'(i % 4));

    // Downstream backpressure for 10 cycles in SEND
    do_reset();
    out_ack = 1'b0;
    pq[0] = '{32'h12345678, TERM};
    drive_inputs();
    for (int i = 0; i < 20 && !output_out_stb; i++) cycle();
    check("bp_reach_send", {31'd0, output_out_stb}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check($sformatf("bp_stb%0d", i), {31'd0, output_out_stb}, 32'd1);
      check($sformatf("bp_data%0d", i), output_out, 32'h12345678);
      check($sformatf("bp_acks%0d", i), {28'd0, acks()}, 32'd0);
    end
    check("bp_none_yet", 32'(out_log.size()), 32'd0);
    out_ack = 1'b1;
    cycle();
    check("bp_first_ack", 32'(out_log.size()), 32'd1);
    check("bp_word", (out_log.size() > 0) ? out_log[0] : 32'hDEADBEEF, 32'h12345678);
    run_until_idle(100, ok);
    check("bp_done", {31'd0, ok}, 32'd1);
    check("bp_total", 32'(out_log.size()), 32'd2);

    // Stall timeout: requester 3 sends one word then drops stb
    do_reset();
    pq[3] = '{32'h41};
    drive_inputs();
    for (int i = 0; i < 20 && gnt_log.size() == 0; i++) cycle();
    pq[0] = '{TERM};
    drive_inputs();
    stall_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (exception) break;
      if (ack3 && !stb[3]) stall_cnt++;
    end
    check("to_stall_cycles", 32'(stall_cnt), 32'(TOUT));
    check("to_exc", {31'd0, exception}, 32'd1);
    run_until_idle(100, ok);
    check("to_done", {31'd0, ok}, 32'd1);
    check("to_next_grant", (gnt_log.size() > 1) ? 32'(gnt_log[1]) : 32'hDEADBEEF, 32'd0);
    check("to_out0", (out_log.size() > 0) ? out_log[0] : 32'hDEADBEEF, 32'h41);
    for (int i = 0; i < 5; i++) cycle();
    check("to_exc_sticky", {31'd0, exception}, 32'd1);
    do_reset();
    check("to_exc_cleared", {31'd0, exception}, 32'd0);

    // Word limit: 6 words from requester 0, requester 1 waiting
    pq[0] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, TERM};
    pq[1] = '{TERM};
    drive_inputs();
    run_until_idle(200, ok);
    check("mw_done", {31'd0, ok}, 32'd1);
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, TERM, 32'd5, 32'd6, TERM};
    check("mw_count", 32'(out_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("mw_w%0d", i), (i < out_log.size()) ? out_log[i] : 32'hDEADBEEF, exp_q[i]);
    check("mw_g4", (gnt_log.size() > 4) ? 32'(gnt_log[4]) : 32'hDEADBEEF, 32'd1);

    // Reset while a producer is being acked: no word taken
    do_reset();
    pq[0] = '{32'h77};
    drive_inputs();
    for (int i = 0; i < 10 && !ack0; i++) cycle();
    rst = 1'b1;
    #1;
    check("rsta_ack_in_rst", {31'd0, ack0}, 32'd0);
    cycle();
    check("rsta_no_xfer", 32'(gnt_log.size()), 32'd0);
    check("rsta_acks", {28'd0, acks()}, 32'd0);
    do_reset();

    // Reset during SEND
    out_ack = 1'b0;
    pq[0] = '{32'h55, TERM};
    drive_inputs();
    for (int i = 0; i < 20 && !output_out_stb; i++) cycle();
    check("rsts_in_send", {31'd0, output_out_stb}, 32'd1);
    rst = 1'b1;
    cycle();
    check("rsts_stb", {31'd0, output_out_stb}, 32'd0);
    check("rsts_out", output_out, 32'd0);
    check("rsts_acks", {28'd0, acks()}, 32'd0);
    out_ack = 1'b1;
    do_reset();

    // Random messages, producer stalls and downstream backpressure
    gap_en = 1'b1;
    ack_rand = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 5; m++) begin
        int len;
        logic [31:0] w;
        len = $urandom_range(1, 6);
        for (int j = 0; j < len - 1; j++) begin
          w = $urandom;
          if (w == TERM) w = w + 32'd1;
          pq[k].push_back(w);
        end
        pq[k].push_back(TERM);
      end
    end
    // Reference: split each queue into messages (terminator or word limit),
    // then serve whole messages round-robin among requesters with work left.
    begin
      int head [4];
      int last;
      bit any;
      exp_q.delete();
      last = 3;
      for (int k = 0; k < 4; k++) head[k] = 0;
      any = 1'b1;
      while (any) begin
        any = 1'b0;
        for (int i = 1; i <= 4; i++) begin
          int k;
          k = (last + i) % 4;
          if (head[k] < pq[k].size()) begin
            int cnt;
            logic [31:0] w;
            cnt = 0;
            do begin
              w = pq[k][head[k]];
              head[k]++;
              cnt++;
              exp_q.push_back(w);
            end while (w != TERM && cnt != MAXW && head[k] < pq[k].size());
            last = k;
            any = 1'b1;
            break;
          end
        end
      end
    end
    drive_inputs();
    run_until_idle(5000, ok);
    check("rnd_done", {31'd0, ok}, 32'd1);
    check("rnd_count", 32'(out_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rnd_w%0d", i), (i < out_log.size()) ? out_log[i] : 32'hDEADBEEF, exp_q[i]);
    check("rnd_exc", {31'd0, exception}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
